// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the ctrl_pipe decode-and-carry unit.
// Optional feature macro: RV32M_EN (mul/div decode and EX interlock).
package ctrl_pipe_pkg;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011
    } rv32i_opcode_t;

    // Encoding matches funct3 for add/sll/xor/srl/or/and so those map directly.
    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops_t;

    typedef enum logic [2:0] {
        md_mul = 3'b000, md_mulh = 3'b001, md_mulhsu = 3'b010, md_mulhu = 3'b011,
        md_div = 3'b100, md_divu = 3'b101, md_rem    = 3'b110, md_remu  = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        rf_alu_out, rf_br_en, rf_u_imm, rf_load, rf_pc_plus4
    } regfilemux_sel_t;

    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] CMP_BLT       = 3'b100;
    localparam logic [2:0] CMP_BLTU      = 3'b110;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        alu_ops_t        aluop;
        logic [2:0]      cmpop;
        logic            alumux1_sel;   // 0: rs1, 1: pc
        logic            alumux2_sel;   // 0: imm, 1: rs2
        logic            cmpmux_sel;    // 0: rs2, 1: imm
        regfilemux_sel_t regfilemux_sel;
        muldiv_op_t      md_op;
        logic            load_regfile;
        logic            dmem_read;
        logic            dmem_write;
    } ctrl_word_t;

    typedef struct packed {
        logic       valid;
        logic       trap;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       muldiv;
        ctrl_word_t ctrl;
    } ctrl_stage_t;

    localparam ctrl_word_t CTRL_DEFAULT = '{
        opcode: 7'b0, funct3: 3'b0, aluop: alu_add, cmpop: 3'b0,
        alumux1_sel: 1'b0, alumux2_sel: 1'b0, cmpmux_sel: 1'b0,
        regfilemux_sel: rf_alu_out, md_op: md_mul,
        load_regfile: 1'b0, dmem_read: 1'b0, dmem_write: 1'b0
    };

    localparam ctrl_stage_t CTRL_BUBBLE = '{
        valid: 1'b0, trap: 1'b0, rs1: 5'b0, rs2: 5'b0, rd: 5'b0,
        muldiv: 1'b0, ctrl: CTRL_DEFAULT
    };

    // Keep a stage's fields for debug visibility but strip every side effect.
    function automatic ctrl_stage_t to_bubble(input ctrl_stage_t s);
        ctrl_stage_t b;
        b                   = s;
        b.valid             = 1'b0;
        b.trap              = 1'b0;
        b.muldiv            = 1'b0;
        b.ctrl.load_regfile = 1'b0;
        b.ctrl.dmem_read    = 1'b0;
        b.ctrl.dmem_write   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational RV32I decoder: instruction word -> stage control word.
// Optional feature macro: RV32M_EN (decode funct7=0000001 op_reg as mul/div).
module ctrl_pipe_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_stage_t dec,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       arith;
    logic       is_reg;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Decode table, then shared ALU selection for op_imm/op_reg.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        dec                = CTRL_BUBBLE;
        dec.valid          = 1'b1;
        dec.rs1            = instr[19:15];
        dec.rs2            = instr[24:20];
        dec.rd             = instr[11:7];
        dec.ctrl.opcode    = opcode;
        dec.ctrl.funct3    = funct3;
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b0;
        arith              = 1'b0;
        is_reg             = 1'b0;

        case (opcode)
            OP_LUI: begin
                uses_rs1                 = 1'b0;
                dec.ctrl.regfilemux_sel  = rf_u_imm;
                dec.ctrl.load_regfile    = 1'b1;
            end
            OP_AUIPC: begin
                uses_rs1                 = 1'b0;
                dec.ctrl.alumux1_sel     = 1'b1;
                dec.ctrl.load_regfile    = 1'b1;
            end
            OP_JAL: begin
                uses_rs1                 = 1'b0;
                dec.ctrl.alumux1_sel     = 1'b1;
                dec.ctrl.regfilemux_sel  = rf_pc_plus4;
                dec.ctrl.load_regfile    = 1'b1;
            end
            OP_JALR: begin
                dec.ctrl.regfilemux_sel  = rf_pc_plus4;
                dec.ctrl.load_regfile    = 1'b1;
            end
            OP_BR: begin
                uses_rs2                 = 1'b1;
                dec.ctrl.cmpop           = funct3;
                dec.ctrl.alumux1_sel     = 1'b1;
                dec.rd                   = 5'd0;
            end
            OP_LOAD: begin
                dec.ctrl.dmem_read       = 1'b1;
                dec.ctrl.regfilemux_sel  = rf_load;
                dec.ctrl.load_regfile    = 1'b1;
            end
            OP_STORE: begin
                uses_rs2                 = 1'b1;
                dec.ctrl.dmem_write      = 1'b1;
                dec.rd                   = 5'd0;
            end
            OP_IMM: begin
                dec.ctrl.cmpmux_sel      = 1'b1;
                dec.ctrl.load_regfile    = 1'b1;
                arith                    = 1'b1;
            end
            OP_REG: begin
                uses_rs2                 = 1'b1;
                dec.ctrl.alumux2_sel     = 1'b1;
                if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EN
                    dec.muldiv               = 1'b1;
                    dec.ctrl.md_op           = muldiv_op_t'(funct3);
                    dec.ctrl.regfilemux_sel  = rf_alu_out;
                    dec.ctrl.load_regfile    = 1'b1;
`else
                    dec.trap                 = 1'b1;
`endif
                end else begin
                    dec.ctrl.load_regfile    = 1'b1;
                    arith                    = 1'b1;
                    is_reg                   = 1'b1;
                end
            end
            default: dec.trap = 1'b1;
        endcase

        if (arith) begin
            case (funct3)
                3'b010: begin
                    dec.ctrl.cmpop          = CMP_BLT;
                    dec.ctrl.regfilemux_sel = rf_br_en;
                end
                3'b011: begin
                    dec.ctrl.cmpop          = CMP_BLTU;
                    dec.ctrl.regfilemux_sel = rf_br_en;
                end
                3'b101:  dec.ctrl.aluop = (funct7 == FUNCT7_ALT) ? alu_sra : alu_srl;
                // addi has no subtract form; its upper bits are immediate.
                3'b000:  dec.ctrl.aluop = (is_reg && funct7 == FUNCT7_ALT) ? alu_sub : alu_add;
                default: dec.ctrl.aluop = alu_ops_t'(funct3);
            endcase
        end

        if (dec.rd == 5'd0) dec.ctrl.load_regfile = 1'b0;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Decode-once control pipeline with stall, flush, load-use and mul/div interlocks.
// Optional feature macro: RV32M_EN (multi-cycle mul/div occupancy of stage 0).
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int FLUSH_DEPTH   = 2,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid_i,
    output logic                         id_ready_o,
    input  logic [31:0]                  instr_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output ctrl_stage_t [NUM_STAGES-1:0] stage_o
);

    if (NUM_STAGES < 2 || NUM_STAGES > 6 || FLUSH_DEPTH < 1 ||
        FLUSH_DEPTH > NUM_STAGES || MULDIV_CYCLES < 1) begin : g_param_check
        $error("ctrl_pipe: illegal parameter combination");
    end

    // Stage that receives the squashed remnant of the last flushed stage.
    localparam int FD_IDX = (FLUSH_DEPTH < NUM_STAGES) ? FLUSH_DEPTH : NUM_STAGES - 1;

    ctrl_stage_t [NUM_STAGES-1:0] stage_q;
    ctrl_stage_t [NUM_STAGES-1:0] stage_d;
    ctrl_stage_t                  dec;
    logic                         uses_rs1;
    logic                         uses_rs2;
    logic                         load_use;
    logic                         md_busy;
    logic                         accept;

    ctrl_pipe_decode u_decode (
        .instr    (instr_i),
        .dec      (dec),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign load_use = stage_q[0].valid && stage_q[0].ctrl.dmem_read && (stage_q[0].rd != 5'd0) &&
                      (((stage_q[0].rd == dec.rs1) && uses_rs1) ||
                       ((stage_q[0].rd == dec.rs2) && uses_rs2));

    assign id_ready_o = !rst && !stall_i && !load_use && !md_busy;
    assign accept     = id_valid_i && id_ready_o;
    assign stage_o    = stage_q;

`ifdef RV32M_EN
    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    logic [CW-1:0] md_cnt_q;

    assign md_busy = (md_cnt_q != '0);

    // Remaining EX cycles of the mul/div op occupying stage 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else if (flush_i) begin
            md_cnt_q <= '0;
        end else if (!stall_i) begin
            if (md_busy)                  md_cnt_q <= md_cnt_q - 1'b1;
            else if (accept && dec.muldiv) md_cnt_q <= CW'(MULDIV_CYCLES - 1);
        end
    end
`else
    assign md_busy = 1'b0;
`endif

    // Next stage contents: hold, shift, interlock bubbles, then flush override.
    always_comb begin
        stage_d = stage_q;
        if (!stall_i) begin
            for (int k = NUM_STAGES - 1; k >= 2; k--) stage_d[k] = stage_q[k-1];
            if (md_busy) begin
                stage_d[1] = CTRL_BUBBLE;
            end else begin
                stage_d[1] = stage_q[0];
                stage_d[0] = accept ? dec : CTRL_BUBBLE;
            end
        end
        if (flush_i) begin
            for (int k = 0; k < FLUSH_DEPTH; k++) stage_d[k] = CTRL_BUBBLE;
            if (FLUSH_DEPTH < NUM_STAGES && !stall_i) stage_d[FD_IDX] = to_bubble(stage_q[FD_IDX-1]);
        end
    end

    // Stage register array; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
        if (rst) stage_q <= {NUM_STAGES{CTRL_BUBBLE}};
        else     stage_q <= stage_d;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe (NUM_STAGES=3, FLUSH_DEPTH=2, MULDIV_CYCLES=4).
// Covers both builds of macro RV32M_EN.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam logic [31:0] I_ADD3  = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] I_SUB4  = 32'h40208233;  // sub  x4,x1,x2
    localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] I_MUL7  = 32'h022083B3;  // mul  x7,x1,x2
    localparam logic [31:0] I_ADDI0 = 32'h00500013;  // addi x0,x0,5
    localparam logic [31:0] I_SW    = 32'h0020A423;  // sw   x2,8(x1)
    localparam logic [31:0] I_BAD   = 32'h0000007F;  // unknown opcode

    logic                  clk;
    logic                  rst;
    logic                  id_valid_i;
    logic                  id_ready_o;
    logic [31:0]           instr_i;
    logic                  stall_i;
    logic                  flush_i;
    ctrl_stage_t [2:0]     stage_o;

    int total;
    int bad;

    ctrl_pipe #(.NUM_STAGES(3), .FLUSH_DEPTH(2), .MULDIV_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid_i (id_valid_i),
        .id_ready_o (id_ready_o),
        .instr_i    (instr_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .stage_o    (stage_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        id_valid_i = 1'b0;
        instr_i    = 32'h0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;

        // Reset state
        #3;
        check("rst_ready", 32'(id_ready_o), 32'd0);
        check("rst_v0", 32'(stage_o[0].valid), 32'd0);
        check("rst_v2", 32'(stage_o[2].valid), 32'd0);
        check("rst_lrf0", 32'(stage_o[0].ctrl.load_regfile), 32'd0);
        #9;
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(id_ready_o), 32'd1);

        // add x3,x1,x2: one-cycle decode, reaches stage 2 two cycles later
        id_valid_i = 1'b1;
        instr_i    = I_ADD3;
        tick();
        check("add_v0", 32'(stage_o[0].valid), 32'd1);
        check("add_rd", 32'(stage_o[0].rd), 32'd3);
        check("add_rs", {stage_o[0].rs1, stage_o[0].rs2}, {22'd0, 5'd1, 5'd2});
        check("add_lrf", 32'(stage_o[0].ctrl.load_regfile), 32'd1);
        check("add_aluop", 32'(stage_o[0].ctrl.aluop), 32'(alu_add));
        check("add_trap", 32'(stage_o[0].trap), 32'd0);
        id_valid_i = 1'b0;
        tick();
        check("add_s1", 32'(stage_o[1].rd), 32'd3);
        tick();
        check("add_s2_v", 32'(stage_o[2].valid), 32'd1);
        check("add_s2_rd", 32'(stage_o[2].rd), 32'd3);
        check("add_s0_bub", 32'(stage_o[0].valid), 32'd0);

        // sub selects alu_sub via funct7
        id_valid_i = 1'b1;
        instr_i    = I_SUB4;
        tick();
        check("sub_aluop", 32'(stage_o[0].ctrl.aluop), 32'(alu_sub));
        check("sub_rd", 32'(stage_o[0].rd), 32'd4);
        id_valid_i = 1'b0;
        tick();
        tick();

        // Load-use: exactly one bubble between lw x5 and add x6,x5,x2
        id_valid_i = 1'b1;
        instr_i    = I_LW5;
        #1;
        check("lw_ready", 32'(id_ready_o), 32'd1);
        tick();
        check("lw_dread", 32'(stage_o[0].ctrl.dmem_read), 32'd1);
        instr_i = I_ADD6;
        #1;
        check("lu_ready0", 32'(id_ready_o), 32'd0);
        tick();
        check("lu_bubble", 32'(stage_o[0].valid), 32'd0);
        check("lu_lw_s1", 32'(stage_o[1].rd), 32'd5);
        check("lu_ready1", 32'(id_ready_o), 32'd1);
        tick();
        check("lu_add_v", 32'(stage_o[0].valid), 32'd1);
        check("lu_add_rd", 32'(stage_o[0].rd), 32'd6);
        check("lu_lw_s2", 32'(stage_o[2].rd), 32'd5);

        // Flush with all stages valid: stages 0,1 bubble, old stage 1 lands squashed in stage 2
        instr_i = I_ADD3;
        tick();
        instr_i = I_SUB4;
        tick();
        check("fl_full", {stage_o[0].valid, stage_o[1].valid, stage_o[2].valid}, 32'd7);
        instr_i = I_ADD3;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_v", {stage_o[0].valid, stage_o[1].valid, stage_o[2].valid}, 32'd0);
        check("fl_s2_rd", 32'(stage_o[2].rd), 32'd3);
        check("fl_s2_lrf", 32'(stage_o[2].ctrl.load_regfile), 32'd0);

        // Stall for 3 cycles with a full pipe, then one shift per cycle
        instr_i = I_ADD3;
        tick();
        instr_i = I_SUB4;
        tick();
        instr_i = I_ADD6;
        tick();
        stall_i = 1'b1;
        instr_i = I_ADD3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_ready", 32'(id_ready_o), 32'd0);
            tick();
            check("st_hold", {stage_o[0].rd, stage_o[1].rd, stage_o[2].rd}, {17'd0, 5'd6, 5'd4, 5'd3});
        end
        stall_i    = 1'b0;
        id_valid_i = 1'b0;
        tick();
        check("st_shift", {stage_o[0].valid, stage_o[1].rd, stage_o[2].rd}, {21'd0, 1'b0, 5'd6, 5'd4});
        tick();
        tick();

        // mul x7,x1,x2
        id_valid_i = 1'b1;
        instr_i    = I_MUL7;
        tick();
        id_valid_i = 1'b0;
`ifdef RV32M_EN
        check("mul_md", 32'(stage_o[0].muldiv), 32'd1);
        check("mul_lrf", 32'(stage_o[0].ctrl.load_regfile), 32'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mul_busy", 32'(id_ready_o), 32'd0);
            tick();
            check("mul_hold", {stage_o[0].valid, stage_o[0].rd, stage_o[1].valid}, {25'd0, 1'b1, 5'd7, 1'b0});
        end
        #1;
        check("mul_free", 32'(id_ready_o), 32'd1);
        tick();
        check("mul_s1", {stage_o[1].valid, stage_o[1].rd}, {26'd0, 1'b1, 5'd7});
`else
        check("mul_trap", 32'(stage_o[0].trap), 32'd1);
        check("mul_lrf", 32'(stage_o[0].ctrl.load_regfile), 32'd0);
        check("mul_md", 32'(stage_o[0].muldiv), 32'd0);
        check("mul_ready", 32'(id_ready_o), 32'd1);
`endif
        tick();

        // rd=x0, store, unknown opcode
        id_valid_i = 1'b1;
        instr_i    = I_ADDI0;
        tick();
        check("addi0", {stage_o[0].valid, stage_o[0].ctrl.load_regfile}, 32'd2);
        instr_i = I_SW;
        tick();
        check("sw", {stage_o[0].rd, stage_o[0].ctrl.dmem_write, stage_o[0].ctrl.load_regfile}, 32'd2);
        instr_i = I_BAD;
        tick();
        check("bad_op", {stage_o[0].valid, stage_o[0].trap, stage_o[0].ctrl.load_regfile,
                         stage_o[0].ctrl.dmem_read, stage_o[0].ctrl.dmem_write}, 32'h18);
        id_valid_i = 1'b0;

        // Asynchronous reset mid-cycle clears everything before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_v", {stage_o[0].valid, stage_o[1].valid, stage_o[2].valid}, 32'd0);
        check("arst_ready", 32'(id_ready_o), 32'd0);
        #3;
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
